bid_collector: RTL and testbench

- Upstream stage of the 10-way argmax auction datapath.
- Accepts bids one at a time over a valid/ready stream, tagged by bidder ID, and assembles one auction round into a stable bid vector driven into argmax10.
- After the round closes it samples the argmax winner and presents a registered result record (winner, winning bid, bid count, timeout flag) downstream through a valid/ready handshake.

---
 rtl/bid_collector.sv | 161 ++++++++++++++++
 tb/tb_bid_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bid_collector.sv
// Auction bid collector: gathers one round of tagged bids into a stable vector
// for argmax10, then captures the winner into a registered result record.
module bid_collector #(
  parameter int N_BIDDERS   = 10,
  parameter int BID_W       = 17,
  parameter int ID_W        = 4,
  parameter int TIMEOUT     = 64,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ID_W-1:0]                 in_id,
  input  logic [BID_W-1:0]                in_bid,
  output logic [N_BIDDERS-1:0][BID_W-1:0] bids,
  input  logic [ID_W-1:0]                 winner_in,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ID_W-1:0]                 res_winner,
  output logic [BID_W-1:0]                res_bid,
  output logic [ID_W-1:0]                 res_count,
  output logic                            res_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {COLLECT, EVAL, RESULT} state_t;

  state_t               state_reg;
  logic                 in_ready_reg;
  logic                 res_valid_reg;
  logic [ID_W-1:0]      res_winner_reg;
  logic [BID_W-1:0]     res_bid_reg;
  logic [ID_W-1:0]      res_count_reg;
  logic                 res_timeout_reg;
  logic [N_BIDDERS-1:0] mask_reg;
  logic [ID_W-1:0]      count_reg;
  logic [TW-1:0]        timer_reg;
  logic                 timer_active_reg;
  logic [3:0]           eval_cnt_reg;
  logic                 timeout_flag_reg;

  logic                 accept_ok;
  logic                 clear_round;
  logic [N_BIDDERS-1:0] slot_wr;
  logic                 new_slot;
  logic [ID_W-1:0]      count_next;
  logic [BID_W-1:0]     win_bid;

  // Out-of-range IDs still complete the handshake but never reach a slot.
  assign accept_ok   = in_valid && in_ready_reg && (in_id < ID_W'(N_BIDDERS));
  assign clear_round = (state_reg == RESULT) && res_ready;
  assign new_slot    = |(slot_wr & ~mask_reg);
  assign count_next  = count_reg + ID_W'(new_slot);

  generate
    for (genvar gi = 0; gi < N_BIDDERS; gi++) begin : g_slot
      logic [BID_W-1:0] slot_reg;

      assign slot_wr[gi] = accept_ok && (in_id == ID_W'(gi));
      assign bids[gi]    = slot_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg <= '0;
        end else if (clear_round) begin
          slot_reg <= '0;
        end else if (slot_wr[gi]) begin
          slot_reg <= in_bid;
        end
      end
    end
  endgenerate

  // A winner index past the last slot selects nothing and yields a zero bid.
  always_comb begin
    win_bid = '0;
    for (int i = 0; i < N_BIDDERS; i++) begin
      if (winner_in == ID_W'(i)) win_bid = bids[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= COLLECT;
      in_ready_reg     <= 1'b1;
      res_valid_reg    <= 1'b0;
      res_winner_reg   <= '0;
      res_bid_reg      <= '0;
      res_count_reg    <= '0;
      res_timeout_reg  <= 1'b0;
      mask_reg         <= '0;
      count_reg        <= '0;
      timer_reg        <= '0;
      timer_active_reg <= 1'b0;
      eval_cnt_reg     <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          mask_reg  <= mask_reg | slot_wr;
          count_reg <= count_next;
          if (accept_ok && !timer_active_reg) begin
            timer_active_reg <= 1'b1;
            timer_reg        <= '0;
          end else if (timer_active_reg) begin
            timer_reg <= timer_reg + 1'b1;
          end
          // Filling the last slot wins over a coincident timeout.
          if (count_next == ID_W'(N_BIDDERS)) begin
            state_reg        <= EVAL;
            in_ready_reg     <= 1'b0;
            eval_cnt_reg     <= '0;
            timeout_flag_reg <= 1'b0;
          end else if (timer_active_reg && timer_reg == TW'(TIMEOUT - 1)) begin
            state_reg        <= EVAL;
            in_ready_reg     <= 1'b0;
            eval_cnt_reg     <= '0;
            timeout_flag_reg <= 1'b1;
          end
        end
        EVAL: begin
          if (eval_cnt_reg == 4'(EVAL_CYCLES - 1)) begin
            res_winner_reg  <= winner_in;
            res_bid_reg     <= win_bid;
            res_count_reg   <= count_reg;
            res_timeout_reg <= timeout_flag_reg;
            res_valid_reg   <= 1'b1;
            state_reg       <= RESULT;
          end else begin
            eval_cnt_reg <= eval_cnt_reg + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_reg    <= 1'b0;
            in_ready_reg     <= 1'b1;
            state_reg        <= COLLECT;
            mask_reg         <= '0;
            count_reg        <= '0;
            timer_reg        <= '0;
            timer_active_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= COLLECT;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign res_valid   = res_valid_reg;
  assign res_winner  = res_winner_reg;
  assign res_bid     = res_bid_reg;
  assign res_count   = res_count_reg;
  assign res_timeout = res_timeout_reg;

endmodule

// File: tb/tb_bid_collector.sv
// Directed bench for bid_collector: full rounds, timeouts, duplicates,
// invalid IDs, result backpressure and mid-round reset.
module tb_bid_collector;

  localparam int N_BIDDERS   = 10;
  localparam int BID_W       = 17;
  localparam int ID_W        = 4;
  localparam int TIMEOUT     = 64;
  localparam int EVAL_CYCLES = 1;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            in_valid;
  logic                            in_ready;
  logic [ID_W-1:0]                 in_id;
  logic [BID_W-1:0]                in_bid;
  logic [N_BIDDERS-1:0][BID_W-1:0] bids;
  logic [ID_W-1:0]                 winner_in;
  logic                            res_valid;
  logic                            res_ready;
  logic [ID_W-1:0]                 res_winner;
  logic [BID_W-1:0]                res_bid;
  logic [ID_W-1:0]                 res_count;
  logic                            res_timeout;

  int vectors = 0;
  int miscompares = 0;

  bid_collector #(
    .N_BIDDERS(N_BIDDERS), .BID_W(BID_W), .ID_W(ID_W),
    .TIMEOUT(TIMEOUT), .EVAL_CYCLES(EVAL_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_bid(in_bid),
    .bids(bids), .winner_in(winner_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_winner(res_winner),
    .res_bid(res_bid), .res_count(res_count), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nonzero_slots();
    int n = 0;
    for (int i = 0; i < N_BIDDERS; i++) if (bids[i] != '0) n++;
    return n;
  endfunction

  task automatic send(input int id, input int bid);
    chk("in_ready_collect", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_id    = ID_W'(id);
    in_bid   = BID_W'(bid);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_timely", 32'(res_valid), 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("hs_res_valid", 32'(res_valid), 0);
    chk("hs_in_ready", 32'(in_ready), 1);
    chk("hs_bids_clear", 32'(nonzero_slots()), 0);
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b0; in_valid = 1'b0; in_id = '0; in_bid = '0;
    winner_in = '0; res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_bids", 32'(nonzero_slots()), 0);
    chk("rst_res_count", 32'(res_count), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // Full round, ascending bids.
    winner_in = 4'd9;
    for (int i = 0; i < 10; i++) send(i, 10 * (i + 1));
    chk("full_eval_entered", 32'(in_ready), 0);
    chk("full_bid5", 32'(bids[5]), 60);
    wait_result(n);
    chk("full_latency", 32'(n), EVAL_CYCLES);
    chk("full_winner", 32'(res_winner), 9);
    chk("full_bid", 32'(res_bid), 100);
    chk("full_count", 32'(res_count), 10);
    chk("full_timeout", 32'(res_timeout), 0);

    // Backpressure: result held, no bids accepted.
    in_valid = 1'b1; in_id = 4'd0; in_bid = 17'd999;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("bp_winner", 32'(res_winner), 9);
      chk("bp_bid", 32'(res_bid), 100);
      chk("bp_slot0", 32'(bids[0]), 10);
    end
    handshake();

    // Single bid, round closes by timeout.
    winner_in = 4'd3;
    send(3, 500);
    wait_result(n);
    chk("to_latency", 32'(n), TIMEOUT + EVAL_CYCLES);
    chk("to_winner", 32'(res_winner), 3);
    chk("to_bid", 32'(res_bid), 500);
    chk("to_count", 32'(res_count), 1);
    chk("to_timeout", 32'(res_timeout), 1);
    chk("to_slot3", 32'(bids[3]), 500);
    chk("to_other_slots", 32'(nonzero_slots()), 1);
    handshake();

    // Duplicate ID overwrites without bumping the count.
    winner_in = 4'd5;
    send(5, 50);
    send(5, 7);
    chk("dup_slot5", 32'(bids[5]), 7);
    for (int i = 0; i < 10; i++) if (i != 5) send(i, 1);
    chk("dup_eval_entered", 32'(in_ready), 0);
    wait_result(n);
    chk("dup_slot5_final", 32'(bids[5]), 7);
    chk("dup_count", 32'(res_count), 10);
    chk("dup_winner", 32'(res_winner), 5);
    chk("dup_bid", 32'(res_bid), 7);
    chk("dup_timeout", 32'(res_timeout), 0);
    handshake();

    // Invalid IDs are accepted and dropped; they do not start the timer.
    winner_in = 4'd2;
    send(12, 900);
    send(15, 900);
    chk("inv_in_ready", 32'(in_ready), 1);
    chk("inv_bids", 32'(nonzero_slots()), 0);
    send(2, 30);
    wait_result(n);
    chk("inv_latency", 32'(n), TIMEOUT + EVAL_CYCLES);
    chk("inv_count", 32'(res_count), 1);
    chk("inv_winner", 32'(res_winner), 2);
    chk("inv_bid", 32'(res_bid), 30);
    chk("inv_timeout", 32'(res_timeout), 1);
    handshake();

    // Reset in the middle of a round discards it.
    for (int i = 0; i < 4; i++) send(i, 5);
    rst = 1'b0;
    #1;
    chk("mid_rst_bids", 32'(nonzero_slots()), 0);
    chk("mid_rst_res_valid", 32'(res_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      seen |= res_valid;
    end
    chk("mid_rst_no_result", 32'(seen), 0);
    winner_in = 4'd4;
    for (int i = 0; i < 10; i++) send(i, 3 * (i + 1));
    wait_result(n);
    chk("post_rst_count", 32'(res_count), 10);
    chk("post_rst_winner", 32'(res_winner), 4);
    chk("post_rst_bid", 32'(res_bid), 15);
    chk("post_rst_timeout", 32'(res_timeout), 0);
    handshake();

    // Out-of-range winner index yields a zero winning bid.
    winner_in = 4'd12;
    for (int i = 0; i < 10; i++) send(i, 100 + i);
    wait_result(n);
    chk("oor_winner", 32'(res_winner), 12);
    chk("oor_bid", 32'(res_bid), 0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
